// File: rtl/barrel_pkg.sv
// Shared constants and helpers for the pipelined left-rotate shifter.
// rotl gives the plain rotate-left reference at the default width.
package barrel_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int AMT_W_DEF = 3;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << r) < v) r = r + 1;
      end
      return r;
   endfunction

   function automatic logic [WIDTH_DEF-1:0] rotl(
      input logic [WIDTH_DEF-1:0] d,
      input int unsigned          n
   );
      logic [2*WIDTH_DEF-1:0] t;
      t = {d, d} << (n % WIDTH_DEF);
      return t[2*WIDTH_DEF-1:WIDTH_DEF];
   endfunction

endpackage

// File: rtl/barrel_rotl_stage.sv
// One registered rotate stage: rotates by SHIFT when its amount bit
// is set, and carries valid, data and amount to the next stage.
module barrel_rotl_stage
   import barrel_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int AMT_W = AMT_W_DEF,
   parameter int SHIFT = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_ready,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   input  logic [AMT_W-1:0] i_amt,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic [AMT_W-1:0] o_amt
);

   localparam int BIT = clog2(SHIFT);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic [AMT_W-1:0] r_amt;
   logic [WIDTH-1:0] w_rot;

   // Conditional rotate by this stage's fixed power of two
   always_comb begin
      w_rot = i_data;
      if (i_amt[BIT])
         w_rot = {i_data[WIDTH-1-SHIFT:0],
                  i_data[WIDTH-1:WIDTH-SHIFT]};
   end

   // Stage register; loads whenever the stage is ready
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_amt   <= '0;
      end else if (i_ready) begin
         r_valid <= i_valid;
         r_data  <= w_rot;
         r_amt   <= i_amt;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_amt   = r_amt;

endmodule

// File: rtl/barrel_shifter_pipe_l.sv
// Pipelined rotate-left barrel shifter, one stage per amount bit,
// with valid/ready flow control and collapsing bubbles.
module barrel_shifter_pipe_l
   import barrel_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int AMT_W = AMT_W_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [AMT_W-1:0] amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y
);

   logic [AMT_W:0]   w_v;
   logic [AMT_W-1:0] w_rdy;
   logic [WIDTH-1:0] w_d [0:AMT_W];
   logic [AMT_W-1:0] w_a [0:AMT_W];
   logic [AMT_W-1:0] w_amt_unused;

   assign w_v[0] = in_valid;
   assign w_d[0] = a;
   assign w_a[0] = amt;

   for (genvar k = 0; k < AMT_W; k++) begin : g_stage
      // Stage k is blocked only if it and every later stage hold
      // data while the consumer stalls; flattened to avoid a
      // ready chain through one vector.
      assign w_rdy[k] = out_ready | ~(&w_v[AMT_W:k+1]);

      barrel_rotl_stage #(
         .WIDTH (WIDTH),
         .AMT_W (AMT_W),
         .SHIFT (1 << k)
      ) u_stage (
         .clk     (clk),
         .reset_n (reset_n),
         .i_ready (w_rdy[k]),
         .i_valid (w_v[k]),
         .i_data  (w_d[k]),
         .i_amt   (w_a[k]),
         .o_valid (w_v[k+1]),
         .o_data  (w_d[k+1]),
         .o_amt   (w_a[k+1])
      );
   end

   assign w_amt_unused = w_a[AMT_W];

   assign in_ready  = w_rdy[0];
   assign out_valid = w_v[AMT_W];
   assign y         = w_d[AMT_W];

endmodule

// File: tb/tb_barrel_shifter_pipe_l.sv
// Bench for barrel_shifter_pipe_l: random and directed streams
// checked against a queue-based rotate reference.
module tb_barrel_shifter_pipe_l;
   import barrel_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [2:0] amt;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] y;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      logic [7:0] y;
      logic [7:0] a;
      logic [2:0] amt;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   barrel_shifter_pipe_l dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .amt       (amt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y)
   );

   function automatic logic [7:0] rotr(input logic [7:0] d,
                                       input int n);
      logic [15:0] t;
      t = {d, d} >> n;
      return t[7:0];
   endfunction

   // Called at a falling edge with inputs already driven: samples
   // the handshake for the coming rising edge, updates the model
   // queue, then waits for the next falling edge.
   task automatic tick(output bit acc, output bit dlv,
                       output bit ov, output logic [7:0] yv,
                       output exp_t e, output int lat,
                       output bit none);
      #1;
      acc  = in_valid && in_ready;
      dlv  = out_valid && out_ready;
      ov   = out_valid;
      yv   = y;
      lat  = -1;
      none = 1'b0;
      e    = '{8'h00, 8'h00, 3'd0, 0};
      if (exp_q.size() > 0) e = exp_q[0];
      if (dlv) begin
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            lat = cyc - e.cyc;
         end else begin
            none = 1'b1;
         end
      end
      if (acc) exp_q.push_back('{rotl(a, amt), a, amt, cyc});
      cyc++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = 8'h00;
      amt       = 3'd0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || y !== 8'h00 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_hold ov=%b y=%h rdy=%b want 0 00 1",
                  out_valid, y, in_ready);
      end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || y !== 8'h00 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release ov=%b y=%h rdy=%b want 0 00 1",
                  out_valid, y, in_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_single();
      bit acc, dlv, ov, none, seen;
      logic [7:0] yv;
      exp_t e;
      int lat;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      a         = 8'h81;
      amt       = 3'd1;
      tick(acc, dlv, ov, yv, e, lat, none);
      n_tests++;
      if (!acc) begin
         n_fail++;
         $display("FAIL single_accept acc=%b want 1", acc);
      end
      in_valid = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         tick(acc, dlv, ov, yv, e, lat, none);
         if (dlv) begin
            seen = 1'b1;
            n_tests++;
            if (yv !== 8'h03 || lat != 3) begin
               n_fail++;
               $display("FAIL single_result y=%h lat=%0d want 03 3",
                        yv, lat);
            end
         end
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL single_timeout no output want one result");
      end
   endtask

   task automatic test_back_to_back();
      bit acc, dlv, ov, none;
      logic [7:0] yv;
      exp_t e;
      int lat;
      int ndel;
      int first;
      logic [7:0] want;
      ndel  = 0;
      first = 0;
      out_ready = 1'b1;
      for (int t = 0; t < 20; t++) begin
         in_valid = (t < 8);
         a        = 8'h01;
         amt      = 3'(t);
         tick(acc, dlv, ov, yv, e, lat, none);
         if (t < 8) begin
            n_tests++;
            if (!acc) begin
               n_fail++;
               $display("FAIL b2b_ready t=%0d acc=%b want 1", t, acc);
            end
         end
         if (dlv) begin
            if (ndel == 0) first = t;
            want = 8'h01 << ndel;
            n_tests++;
            if (yv !== want || t != first + ndel) begin
               n_fail++;
               $display("FAIL b2b_out y=%h t=%0d want %h t=%0d",
                        yv, t, want, first + ndel);
            end
            ndel++;
         end
      end
      n_tests++;
      if (ndel != 8) begin
         n_fail++;
         $display("FAIL b2b_count got %0d want 8", ndel);
      end
   endtask

   task automatic test_backpressure();
      bit acc, dlv, ov, none;
      logic [7:0] yv;
      exp_t e;
      int lat;
      int nacc;
      int ndel;
      nacc      = 0;
      out_ready = 1'b0;
      for (int t = 0; t < 5; t++) begin
         in_valid = 1'b1;
         a        = 8'($urandom);
         amt      = 3'($urandom);
         tick(acc, dlv, ov, yv, e, lat, none);
         if (acc) nacc++;
         if (t >= 3) begin
            n_tests++;
            if (ov !== 1'b1 || yv !== e.y || acc) begin
               n_fail++;
               $display("FAIL bp_stall t=%0d ov=%b y=%h acc=%b want 1 %h 0",
                        t, ov, yv, acc, e.y);
            end
         end
      end
      n_tests++;
      if (nacc != 3) begin
         n_fail++;
         $display("FAIL bp_accepted got %0d want 3", nacc);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      ndel      = 0;
      for (int t = 0; t < 10; t++) begin
         tick(acc, dlv, ov, yv, e, lat, none);
         if (dlv) begin
            ndel++;
            n_tests++;
            if (none || yv !== e.y) begin
               n_fail++;
               $display("FAIL bp_drain y=%h want %h extra=%b",
                        yv, e.y, none);
            end
         end
      end
      n_tests++;
      if (ndel != 3) begin
         n_fail++;
         $display("FAIL bp_drain_count got %0d want 3", ndel);
      end
   endtask

   task automatic test_bubbles();
      bit acc, dlv, ov, none;
      logic [7:0] yv;
      exp_t e;
      int lat;
      int sent;
      int got;
      int gap;
      sent = 0;
      got  = 0;
      gap  = 0;
      out_ready = 1'b1;
      for (int t = 0; t < 80 && got < 6; t++) begin
         in_valid = (sent < 6 && gap == 0);
         a        = 8'($urandom);
         amt      = 3'($urandom);
         tick(acc, dlv, ov, yv, e, lat, none);
         if (acc) begin
            sent++;
            gap = $urandom_range(1, 3);
         end else if (gap > 0) begin
            gap--;
         end
         if (dlv) begin
            got++;
            n_tests++;
            if (none || yv !== e.y || lat != 3) begin
               n_fail++;
               $display("FAIL bubble_out y=%h lat=%0d want %h 3",
                        yv, lat, e.y);
            end
         end
      end
      n_tests++;
      if (got != 6) begin
         n_fail++;
         $display("FAIL bubble_count got %0d want 6", got);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit acc, dlv, ov, none, seen;
      logic [7:0] yv;
      exp_t e;
      int lat;
      out_ready = 1'b0;
      for (int t = 0; t < 3; t++) begin
         in_valid = 1'b1;
         a        = 8'($urandom) | 8'h01;
         amt      = 3'($urandom);
         tick(acc, dlv, ov, yv, e, lat, none);
      end
      in_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || y !== 8'h00 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_clear ov=%b y=%h rdy=%b want 0 00 1",
                  out_valid, y, in_ready);
      end
      exp_q.delete();
      @(negedge clk);
      reset_n   = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      a         = 8'hA5;
      amt       = 3'd4;
      tick(acc, dlv, ov, yv, e, lat, none);
      in_valid = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         tick(acc, dlv, ov, yv, e, lat, none);
         if (dlv) begin
            seen = 1'b1;
            n_tests++;
            if (yv !== 8'h5A || lat != 3) begin
               n_fail++;
               $display("FAIL midreset_first y=%h lat=%0d want 5a 3",
                        yv, lat);
            end
         end
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL midreset_timeout no output want 5a");
      end
   endtask

   task automatic test_random();
      bit acc, dlv, ov, none;
      logic [7:0] yv;
      exp_t e;
      int lat;
      int idx;
      int ndel;
      logic [10:0] p;
      idx  = 0;
      ndel = 0;
      for (int t = 0; t < 20000 && ndel < 2048; t++) begin
         p         = 11'(idx);
         in_valid  = (idx < 2048) && ($urandom_range(0, 3) != 0);
         a         = in_valid ? p[10:3] : 8'($urandom);
         amt       = in_valid ? p[2:0]  : 3'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         tick(acc, dlv, ov, yv, e, lat, none);
         if (acc) idx++;
         if (dlv) begin
            ndel++;
            n_tests++;
            if (none || yv !== e.y || rotr(yv, int'(e.amt)) !== e.a) begin
               n_fail++;
               $display("FAIL rand_out a=%h amt=%0d y=%h want %h",
                        e.a, e.amt, yv, e.y);
            end
         end
      end
      n_tests++;
      if (ndel != 2048 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rand_count got %0d left %0d want 2048 0",
                  ndel, exp_q.size());
      end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_bubbles();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
